// File: rtl/uart_tx_fifo.sv
// UART transmitter fronted by a small synchronous FIFO.
// Upstream pushes words with a valid/ready handshake. The FSM pops a word whenever
// the line is free and sends start, data (LSB first), optional parity and stop bits.
// Frames go out back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_BITS-1:0]              tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic                              uart_tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int BCW        = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int LW         = $clog2(FIFO_DEPTH + 1);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int BTW        = $clog2(DATA_BITS);

    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BIT_CYCLES - 1);
    localparam logic [BTW-1:0] DATA_LAST = BTW'(DATA_BITS - 1);
    localparam logic [BTW-1:0] STOP_LAST = BTW'(STOP_BITS - 1);
    localparam logic           ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        count, count_n;
    logic                 full, empty, push, pop;
    logic [DATA_BITS-1:0] head;

    // Transmit side
    state_t               state, state_n;
    logic [BCW-1:0]       baud_cnt, baud_n;
    logic [BTW-1:0]       bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bit, par_n;
    logic                 tx_n, busy_n, load, baud_end;

    assign full       = (count == LW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign tx_ready   = !full;
    assign fifo_level = count;
    assign push       = tx_valid && !full;
    assign pop        = load;
    assign head       = mem[rd_ptr];
    assign baud_end   = (baud_cnt == BAUD_LAST);
    assign count_n    = count + LW'(push) - LW'(pop);

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
        end
    end

    // Next-state, bit timing and line value; a load both pops and starts a frame
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        par_n   = par_bit;
        tx_n    = uart_tx;
        load    = 1'b0;

        if (state != ST_IDLE)
            baud_n = baud_end ? '0 : baud_cnt + BCW'(1);

        case (state)
            ST_IDLE: begin
                tx_n   = 1'b1;
                baud_n = '0;
                bit_n  = '0;
                load   = !empty;
            end
            ST_START: begin
                if (baud_end) begin
                    state_n = ST_DATA;
                    bit_n   = '0;
                    tx_n    = shreg[0];
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_n = '0;
                        if (PARITY != 0) begin
                            state_n = ST_PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = ST_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n   = bit_cnt + BTW'(1);
                        shreg_n = shreg >> 1;
                        tx_n    = shreg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_end) begin
                    state_n = ST_STOP;
                    bit_n   = '0;
                    tx_n    = 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_n = '0;
                        if (!empty) begin
                            load = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n = bit_cnt + BTW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Common frame start from IDLE or straight out of the last stop bit
        if (load) begin
            state_n = ST_START;
            shreg_n = head;
            par_n   = (^head) ^ ODD_PAR;
            tx_n    = 1'b0;
            bit_n   = '0;
            baud_n  = '0;
        end
    end

    assign busy_n = (state_n != ST_IDLE) || (count_n != '0);

    // Transmit state registers; reset forces the line idle immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            par_bit  <= par_n;
            uart_tx  <= tx_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five configurations side by side on one clock/reset.
// A queue-level model expands each popped word into its per-cycle line waveform.
// Hand-computed literal expectations pin key points of that model.
module tb_uart_tx_fifo;

    localparam int NI = 5;
    localparam int BC = 10;
    localparam int B  = 10;
    localparam int DB [NI] = '{8, 8, 8, 8, 5};
    localparam int PR [NI] = '{0, 2, 1, 0, 0};
    localparam int SB [NI] = '{1, 2, 2, 1, 1};
    localparam int DP [NI] = '{16, 16, 16, 4, 16};

    logic        clk = 1'b0;
    logic        rst;
    logic        tv  [NI];
    logic [8:0]  td  [NI];
    logic        utx [NI];
    logic        rdy [NI];
    logic        bsy [NI];
    logic [4:0]  lvl0, lvl1, lvl2, lvl4;
    logic [2:0]  lvl3;
    logic [31:0] lvl [NI];

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    // model state
    int          mq   [NI][16];
    int          mhd  [NI];
    int          mct  [NI];
    logic [15:0] fb   [NI];
    int          fnb  [NI];
    int          ft   [NI];
    logic        fact [NI];

    always #5 clk = ~clk;

    always_comb begin
        lvl[0] = 32'(lvl0);
        lvl[1] = 32'(lvl1);
        lvl[2] = 32'(lvl2);
        lvl[3] = {29'd0, lvl3};
        lvl[4] = 32'(lvl4);
    end

    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
        .clk(clk), .rst(rst), .tx_data(td[0][7:0]), .tx_valid(tv[0]), .tx_ready(rdy[0]),
        .uart_tx(utx[0]), .busy(bsy[0]), .fifo_level(lvl0));
    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(16)) u1 (
        .clk(clk), .rst(rst), .tx_data(td[1][7:0]), .tx_valid(tv[1]), .tx_ready(rdy[1]),
        .uart_tx(utx[1]), .busy(bsy[1]), .fifo_level(lvl1));
    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(16)) u2 (
        .clk(clk), .rst(rst), .tx_data(td[2][7:0]), .tx_valid(tv[2]), .tx_ready(rdy[2]),
        .uart_tx(utx[2]), .busy(bsy[2]), .fifo_level(lvl2));
    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .tx_data(td[3][7:0]), .tx_valid(tv[3]), .tx_ready(rdy[3]),
        .uart_tx(utx[3]), .busy(bsy[3]), .fifo_level(lvl3));
    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(5), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u4 (
        .clk(clk), .rst(rst), .tx_data(td[4][4:0]), .tx_valid(tv[4]), .tx_ready(rdy[4]),
        .uart_tx(utx[4]), .busy(bsy[4]), .fifo_level(lvl4));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame as a bit list: start 0, data LSB first, optional parity, stop 1s.
    function automatic logic [15:0] mk_frame(input logic [31:0] d, input int db, input int par,
                                             input int sb, output int nb);
        logic [15:0] f;
        logic        p;
        int          n;
        f = '0;
        p = 1'b0;
        n = 1;
        for (int b = 0; b < db; b++) begin
            f[n] = d[b];
            p    = p ^ d[b];
            n++;
        end
        if (par != 0) begin
            f[n] = (par == 1) ? ~p : p;
            n++;
        end
        for (int s = 0; s < sb; s++) begin
            f[n] = 1'b1;
            n++;
        end
        nb = n;
        return f;
    endfunction

    task automatic model_reset(input int i);
        mhd[i]  = 0;
        mct[i]  = 0;
        fact[i] = 1'b0;
        ft[i]   = 0;
        fnb[i]  = 0;
        fb[i]   = '0;
    endtask

    // One clock edge: the line consumes a cycle, a free line takes the head word,
    // and an accepted write lands behind what was queued before the edge.
    task automatic model_step(input int i);
        int pre, hd, nb;
        pre = mct[i];
        hd  = mhd[i];
        if (fact[i]) begin
            ft[i]++;
            if (ft[i] >= fnb[i] * BC) fact[i] = 1'b0;
        end
        if (!fact[i] && pre > 0) begin
            fb[i]   = mk_frame(32'(mq[i][hd]), DB[i], PR[i], SB[i], nb);
            fnb[i]  = nb;
            ft[i]   = 0;
            fact[i] = 1'b1;
            mhd[i]  = (hd + 1) % DP[i];
            mct[i]--;
        end
        if (tv[i] === 1'b1 && pre < DP[i]) begin
            mq[i][(hd + pre) % DP[i]] = int'(td[i]) & ((1 << DB[i]) - 1);
            mct[i]++;
        end
    endtask

    // Compare process: model advances on each edge, outputs checked 1ns later
    initial begin
        for (int i = 0; i < NI; i++) model_reset(i);
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < NI; i++) begin
                if (!rst) model_reset(i);
                else      model_step(i);
            end
            #1;
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("u%0d uart_tx", i), 32'(utx[i]),
                    32'(fact[i] ? fb[i][ft[i] / BC] : 1'b1));
                chk($sformatf("u%0d tx_ready", i), 32'(rdy[i]), 32'(mct[i] < DP[i]));
                chk($sformatf("u%0d busy", i), 32'(bsy[i]), 32'(fact[i] || mct[i] > 0));
                chk($sformatf("u%0d fifo_level", i), lvl[i], 32'(mct[i]));
            end
        end
    end

    task automatic at_neg(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_at(input int i, input logic [8:0] d, input int k);
        at_neg(k - 1);
        tv[i] = 1'b1;
        td[i] = d;
        at_neg(k);
        tv[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Directed stimulus with literal expectations
    initial begin
        int k;
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            tv[i] = 1'b0;
            td[i] = '0;
        end

        at_neg(3);
        chk("reset uart_tx", 32'(utx[0]), 32'd1);
        chk("reset busy", 32'(bsy[0]), 32'd0);
        at_neg(5);
        rst = 1'b1;
        at_neg(7);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("post-reset u%0d uart_tx", i), 32'(utx[i]), 32'd1);
            chk($sformatf("post-reset u%0d tx_ready", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("post-reset u%0d busy", i), 32'(bsy[i]), 32'd0);
            chk($sformatf("post-reset u%0d level", i), lvl[i], 32'd0);
        end

        fork
            // single 8N1 frame of 0xA5
            begin : t_single
                logic [9:0] pat;
                pat = 10'b1_10100101_0;
                push_at(0, 9'h0A5, B);
                chk("a5 idle on write edge", 32'(utx[0]), 32'd1);
                chk("a5 busy after write", 32'(bsy[0]), 32'd1);
                chk("a5 level after write", lvl[0], 32'd1);
                for (int j = 0; j < 10; j++) begin
                    at_neg(B + 1 + 10 * j);
                    chk($sformatf("a5 bit%0d first", j), 32'(utx[0]), 32'(pat[j]));
                    at_neg(B + 10 + 10 * j);
                    chk($sformatf("a5 bit%0d last", j), 32'(utx[0]), 32'(pat[j]));
                end
                chk("a5 busy in last stop cycle", 32'(bsy[0]), 32'd1);
                at_neg(B + 101);
                chk("a5 busy after frame", 32'(bsy[0]), 32'd0);
                chk("a5 line idle after frame", 32'(utx[0]), 32'd1);
            end
            // 0x07 with even/2 stop (u1) and odd/2 stop (u2)
            begin : t_parity
                at_neg(B - 1);
                tv[1] = 1'b1; td[1] = 9'h007;
                tv[2] = 1'b1; td[2] = 9'h007;
                at_neg(B);
                tv[1] = 1'b0;
                tv[2] = 1'b0;
                at_neg(B + 86);
                chk("07 even data bit7", 32'(utx[1]), 32'd0);
                chk("07 odd data bit7", 32'(utx[2]), 32'd0);
                at_neg(B + 91);
                chk("07 even parity first", 32'(utx[1]), 32'd1);
                chk("07 odd parity first", 32'(utx[2]), 32'd0);
                at_neg(B + 100);
                chk("07 even parity last", 32'(utx[1]), 32'd1);
                chk("07 odd parity last", 32'(utx[2]), 32'd0);
                at_neg(B + 101);
                chk("07 odd stop start", 32'(utx[2]), 32'd1);
                at_neg(B + 120);
                chk("07 busy end of 2nd stop", 32'(bsy[1]), 32'd1);
                at_neg(B + 121);
                chk("07 busy cleared at 120 clocks", 32'(bsy[1]), 32'd0);
                chk("07 odd busy cleared", 32'(bsy[2]), 32'd0);
            end
            // 5-bit frame and push on the pop edge
            begin : t_narrow
                k = B;
                push_at(4, 9'h01F, k);
                at_neg(k + 1);
                chk("1f start bit", 32'(utx[4]), 32'd0);
                push_at(4, 9'h00A, k + 5);
                at_neg(k + 11);
                chk("1f data bit0", 32'(utx[4]), 32'd1);
                at_neg(k + 60);
                chk("1f data bit4", 32'(utx[4]), 32'd1);
                at_neg(k + 70);
                chk("1f busy in stop", 32'(bsy[4]), 32'd1);
                chk("1f level before collision", lvl[4], 32'd1);
                tv[4] = 1'b1;
                td[4] = 9'h015;
                at_neg(k + 71);
                tv[4] = 1'b0;
                chk("collision level unchanged", lvl[4], 32'd1);
                chk("0a starts with no gap", 32'(utx[4]), 32'd0);
                at_neg(k + 210);
                chk("narrow busy last frame", 32'(bsy[4]), 32'd1);
                at_neg(k + 211);
                chk("narrow busy done", 32'(bsy[4]), 32'd0);
            end
            // backpressure on depth-4 FIFO
            begin : t_bp
                int b, k0, n, g;
                logic acc;
                b = 1; k0 = 0; g = 0;
                at_neg(B - 1);
                tv[3] = 1'b1;
                while (b <= 6 && g < 1000) begin
                    td[3] = 9'(b);
                    acc   = rdy[3];
                    @(negedge clk);
                    g++;
                    if (acc) begin
                        if (b == 1) k0 = cyc;
                        b++;
                    end
                    if (b > 1) begin
                        n = cyc - k0;
                        if (n == 4) begin
                            chk("bp level full", lvl[3], 32'd4);
                            chk("bp ready low when full", 32'(rdy[3]), 32'd0);
                        end
                        if (n == 101) begin
                            chk("bp level after pop", lvl[3], 32'd3);
                            chk("bp ready after pop", 32'(rdy[3]), 32'd1);
                            chk("bp frame2 back-to-back", 32'(utx[3]), 32'd0);
                        end
                        if (n == 102) chk("bp level refilled", lvl[3], 32'd4);
                    end
                end
                tv[3] = 1'b0;
                if (b <= 6) begin
                    nchk++;
                    nerr++;
                    $display("FAIL bp budget: only %0d bytes accepted, required 6", b - 1);
                end
                at_neg(k0 + 516);
                chk("bp frame6 bit0", 32'(utx[3]), 32'd0);
                at_neg(k0 + 526);
                chk("bp frame6 bit1", 32'(utx[3]), 32'd1);
                at_neg(k0 + 600);
                chk("bp busy last stop", 32'(bsy[3]), 32'd1);
                at_neg(k0 + 601);
                chk("bp busy after 6 frames", 32'(bsy[3]), 32'd0);
            end
        join

        // reset mid-frame with two words queued
        k = cyc + 3;
        push_at(0, 9'h033, k);
        push_at(0, 9'h044, k + 1);
        push_at(0, 9'h055, k + 2);
        at_neg(k + 45);
        chk("mid data bit3 low", 32'(utx[0]), 32'd0);
        chk("mid level 2 queued", lvl[0], 32'd2);
        rst = 1'b0;
        #1;
        chk("async reset line high", 32'(utx[0]), 32'd1);
        chk("async reset level", lvl[0], 32'd0);
        chk("async reset busy", 32'(bsy[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        at_neg(k + 250);
        chk("no frames after reset", 32'(utx[0]), 32'd1);
        chk("idle after reset", 32'(bsy[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
